// File: rtl/ram_message_uart_tx.sv
// ram_message_uart_tx: reads a NUL-terminated ASCII message from the
// message RAM and sends it out as UART 8N1, LSB first.
module ram_message_uart_tx #(
    parameter int DataLength   = 7,
    parameter int AddressBits  = 5,
    parameter int MemorySize   = 21,
    parameter int ClocksPerBit = 10416
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start,
    output logic                   ReadOrWrite,
    output logic [AddressBits-1:0] Address,
    input  logic [DataLength-1:0]  CharIn,
    output logic                   TxSerial,
    output logic                   Busy,
    output logic                   Done,
    output logic [AddressBits:0]   CharsSent
);

    localparam int FrameBits = DataLength + 1;
    localparam int BaudBits  = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
    localparam int BitBits   = (FrameBits > 1) ? $clog2(FrameBits) : 1;

    localparam logic [BaudBits-1:0]    BaudLast = BaudBits'(ClocksPerBit - 1);
    localparam logic [BitBits-1:0]     BitLast  = BitBits'(FrameBits - 1);
    localparam logic [AddressBits-1:0] AddrLast = AddressBits'(MemorySize - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [BaudBits-1:0]  baud;
    logic [BitBits-1:0]   bit_count;
    logic [DataLength:0]  shifter;

    logic baud_last;
    logic bit_last;
    logic addr_last;

    assign ReadOrWrite = 1'b1;
    assign baud_last   = (baud == BaudLast);
    assign bit_last    = (bit_count == BitLast);
    assign addr_last   = (Address == AddrLast);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                if (CharIn == '0) begin
                    state_next = DONE;
                end else begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_last) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_last && bit_last) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_next = addr_last ? DONE : FETCH;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state and the shift register
    always_comb begin
        TxSerial = 1'b1;
        Busy     = 1'b1;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
            end
            START: begin
                TxSerial = 1'b0;
            end
            DATA: begin
                TxSerial = shifter[0];
            end
            DONE: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Baud/bit timing, character shifter, address walk and sent count
    always_ff @(posedge Clock) begin
        if (Reset) begin
            baud      <= '0;
            bit_count <= '0;
            shifter   <= '0;
            Address   <= '0;
            CharsSent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud      <= '0;
                    bit_count <= '0;
                    Address   <= '0;
                    if (Start) begin
                        CharsSent <= '0;
                    end
                end
                LOAD: begin
                    baud      <= '0;
                    bit_count <= '0;
                    shifter   <= {1'b0, CharIn};
                end
                START: begin
                    baud <= baud_last ? '0 : baud + 1'b1;
                end
                DATA: begin
                    if (baud_last) begin
                        baud      <= '0;
                        bit_count <= bit_count + 1'b1;
                        shifter   <= shifter >> 1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud      <= '0;
                        CharsSent <= CharsSent + 1'b1;
                        if (!addr_last) begin
                            Address <= Address + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DONE: begin
                    Address <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_message_uart_tx.sv
// tb_ram_message_uart_tx: message RAM model, cycle-level reference
// timeline built from the frame rules, and a UART line decoder.
module tb_ram_message_uart_tx;

    localparam int CPB = 4;
    localparam int DL  = 7;
    localparam int AB  = 5;
    localparam int MS  = 21;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          rw;
    logic [AB-1:0] addr;
    logic [DL-1:0] char_in;
    logic          tx;
    logic          busy;
    logic          done;
    logic [AB:0]   cs;

    always #5 clk = ~clk;

    logic [DL-1:0] mem [MS];

    // Registered-read RAM model
    always @(posedge clk) char_in <= mem[addr];

    ram_message_uart_tx #(
        .DataLength  (DL),
        .AddressBits (AB),
        .MemorySize  (MS),
        .ClocksPerBit(CPB)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Start      (start),
        .ReadOrWrite(rw),
        .Address    (addr),
        .CharIn     (char_in),
        .TxSerial   (tx),
        .Busy       (busy),
        .Done       (done),
        .CharsSent  (cs)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit tx;
        bit busy;
        bit done;
        int addr;
        int cs;
    } cyc_t;

    typedef struct {
        string name;
        int    kind;
        int    exp_chars;
        string exp_text;
    } vec_t;

    cyc_t  exp_q[$];
    bit    tx_log[$];
    int    done_seen;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_str(input string name, input string act, input string req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got \"%s\" required \"%s\"", name, act, req);
        end
    endtask

    function automatic void push(bit t, bit b, bit d, int a, int c);
        cyc_t e;
        e.tx = t; e.busy = b; e.done = d; e.addr = a; e.cs = c;
        exp_q.push_back(e);
    endfunction

    // Expected per-cycle line/status after an accepted Start
    task automatic build_model(output int n);
        logic [DL-1:0] ch;
        n = 0;
        while (n < MS && mem[n] != 0) n++;
        exp_q.delete();
        push(1, 1, 0, 0, 0);
        push(1, 1, 0, 0, 0);
        for (int k = 0; k < n; k++) begin
            ch = mem[k];
            for (int j = 0; j < CPB; j++) push(0, 1, 0, k, k);
            for (int b = 0; b < 8; b++)
                for (int j = 0; j < CPB; j++)
                    push((b < DL) ? ch[b] : 1'b0, 1, 0, k, k);
            for (int j = 0; j < CPB; j++) push(1, 1, 0, k, k);
            if (k < MS - 1) begin
                push(1, 1, 0, k + 1, k + 1);
                push(1, 1, 0, k + 1, k + 1);
            end
        end
        push(1, 1, 1, (n == MS) ? MS - 1 : n, n);
        push(1, 0, 0, 0, n);
    endtask

    function automatic string decode();
        string s = "";
        int i = 0;
        byte c;
        while (i < tx_log.size()) begin
            if (tx_log[i] == 1'b0 && (i == 0 || tx_log[i-1] == 1'b1)
                && i + 10 * CPB <= tx_log.size()) begin
                c = 0;
                for (int b = 0; b < 8; b++)
                    c[b] = tx_log[i + CPB * (b + 1) + CPB / 2];
                s = {s, string'(c)};
                i += 10 * CPB;
            end else begin
                i++;
            end
        end
        return s;
    endfunction

    task automatic run_msg(input string name, input bit hold, input int repulse_at);
        bit bad = 0;
        cyc_t e;
        tx_log.delete();
        done_seen = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = hold;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            e = exp_q[i];
            tx_log.push_back(tx);
            if (done === 1'b1) done_seen++;
            if (!bad) begin
                n_cmp++;
                if (tx !== e.tx || busy !== e.busy || done !== e.done
                    || addr !== e.addr || cs !== e.cs) begin
                    n_err++;
                    bad = 1;
                    $display("FAIL %s cycle %0d: tx/busy/done/addr/cs got %b/%b/%b/%0d/%0d required %b/%b/%b/%0d/%0d",
                             name, i + 1, tx, busy, done, addr, cs,
                             e.tx, e.busy, e.done, e.addr, e.cs);
                end
            end
            if (!hold) start = (i + 1 == repulse_at);
        end
    endtask

    task automatic load_mem(input int kind);
        string msg = "ECE433 Fall  2020\n\r\n";
        byte c;
        for (int i = 0; i < MS; i++) begin
            case (kind)
                0: begin
                    if (i < 20) begin
                        c = msg[i];
                        mem[i] = c[6:0];
                    end else begin
                        mem[i] = '0;
                    end
                end
                1: mem[i] = 7'h41;
                2: mem[i] = (i == 0) ? 7'h45 : 7'h00;
                default: mem[i] = '0;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[4];
        int n;
        int nul_pos;
        bit bad;

        vecs[0] = '{"default_msg", 0, 20, "ECE433 Fall  2020\n\r\n"};
        vecs[1] = '{"all_A", 1, 21, {"AAAAAAA", "AAAAAAA", "AAAAAAA"}};
        vecs[2] = '{"E_then_nul", 2, 1, "E"};
        vecs[3] = '{"nul_first", 3, 0, ""};

        load_mem(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", addr, 0);
        check("rst_rw", rw, 1);
        check("rst_cs", cs, 0);

        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50 && !bad; i++) begin
            @(negedge clk);
            n_cmp++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0
                || addr !== '0 || rw !== 1'b1 || cs !== '0) begin
                n_err++;
                bad = 1;
                $display("FAIL idle_hold cycle %0d: tx/busy/done/addr/cs got %b/%b/%b/%0d/%0d required 1/0/0/0/0",
                         i, tx, busy, done, addr, cs);
            end
        end

        for (int v = 0; v < 4; v++) begin
            load_mem(vecs[v].kind);
            build_model(n);
            run_msg(vecs[v].name, 1'b0, 0);
            check({vecs[v].name, "_chars_sent"}, cs, vecs[v].exp_chars);
            check({vecs[v].name, "_done_pulses"}, done_seen, 1);
            check_str({vecs[v].name, "_text"}, decode(), vecs[v].exp_text);
        end

        // Start pulse in the middle of character 3 is ignored
        load_mem(0);
        build_model(n);
        run_msg("repulse_mid_frame", 1'b0, 140);
        check_str("repulse_text", decode(), vecs[0].exp_text);
        check("repulse_chars_sent", cs, 20);

        // Start held high: next message starts right after IDLE
        load_mem(2);
        build_model(n);
        run_msg("held_start", 1'b1, 0);
        @(negedge clk);
        check("held_start_restart_busy", busy, 1);
        check("held_start_restart_cs", cs, 0);
        do_reset();

        // Reset during DATA of character 2
        load_mem(0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_reset_tx", tx, 1);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_done", done, 0);
        check("mid_reset_addr", addr, 0);
        check("mid_reset_cs", cs, 0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("mid_reset_quiet", done_seen, 0);
        build_model(n);
        run_msg("after_reset", 1'b0, 0);
        check_str("after_reset_text", decode(), vecs[0].exp_text);

        // Random messages with optional NUL and random Start glitches
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < MS; i++) mem[i] = 7'($urandom_range(1, 127));
            nul_pos = $urandom_range(0, 27);
            if (nul_pos < MS) mem[nul_pos] = '0;
            build_model(n);
            run_msg($sformatf("random_%0d", r), 1'b0, $urandom_range(3, 400));
            check($sformatf("random_%0d_chars_sent", r), cs, n);
            check($sformatf("random_%0d_done_pulses", r), done_seen, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_message_uart_tx.md
Name: ram_message_uart_tx

Overview:
- Downstream consumer of the 21x7-bit ASCII message RAM.
- Holds the RAM in read mode and walks addresses 0..MemorySize-1.
- Fetches each character with the RAM's 1-cycle registered read latency and serialises it as UART 8N1, LSB first, with bit 7 = 0.
- Stops early on a NUL (7'h00) character. Sits between the message RAM and the board's TX pin.

Parameters:
DataLength, 7, character width read from RAM
AddressBits, 5, RAM address width
MemorySize, 21, number of RAM locations walked
ClocksPerBit, 10416, Clock cycles per UART bit (100 MHz / 9600 baud); benches override to 4

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  level/pulse; sampled only in IDLE to begin one message transmission
ReadOrWrite  output  1  RAM mode select; constant 1 (read), this block never writes
Address  output  AddressBits  RAM address of the character being fetched
CharIn  input  DataLength  RAM OutputValue; valid the cycle after Address was presented
TxSerial  output  1  UART line, idle high
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse when the message ends
CharsSent  output  AddressBits+1  count of characters fully transmitted in the current/last message

Behaviour:
- Reset (synchronous, overrides everything, including mid-frame) applies these next-edge values:
  - state = IDLE, TxSerial = 1, Busy = 0, Done = 0, Address = 0, CharsSent = 0, bit/baud counters = 0.
  - ReadOrWrite = 1 at all times.
- All outputs are registered or decoded from state registers only; there are no combinational paths from inputs.
- States: IDLE, FETCH, LOAD, START, DATA, STOP, DONE.
- IDLE:
  - TxSerial = 1, Address = 0.
  - Start = 1 → FETCH; CharsSent clears to 0 on the same edge.
- FETCH (1 cycle):
  - Address is held stable; the RAM registers the data at the end of this cycle.
- LOAD (1 cycle):
  - Capture {1'b0, CharIn} into an 8-bit shift register.
  - CharIn == 0 → DONE, with nothing transmitted.
  - Otherwise → START.
- START:
  - TxSerial = 0 for ClocksPerBit cycles, then → DATA.
- DATA:
  - 8 bits, LSB first, each held for ClocksPerBit cycles; bit 7 is always 0.
  - After the 8th bit → STOP.
- STOP:
  - TxSerial = 1 for ClocksPerBit cycles.
  - At its last cycle CharsSent increments.
  - If Address == MemorySize-1 → DONE; otherwise Address increments on the same edge and the state → FETCH.
- DONE (1 cycle):
  - Done = 1, Busy = 1, TxSerial = 1, then → IDLE.
- Baud counter:
  - Counts 0..ClocksPerBit-1 and reloads to 0 on entering START, on every bit boundary, and on entering STOP.
  - Its width is wide enough for ClocksPerBit-1.
- Timing:
  - Frame = 10*ClocksPerBit cycles.
  - Per-character cost = 2 + 10*ClocksPerBit cycles; the line idles high for 2 cycles between characters.
  - Start seen in IDLE at cycle n → Busy at n+1, first start-bit low at n+3.
- Start asserted while Busy is ignored: no restart, no queuing.
- Start held high continuously: a new message begins on the cycle after DONE returns to IDLE.
- The address does not wrap; the walk ends after location MemorySize-1 even without a NUL.
- CharsSent holds its value after DONE until the next accepted Start.

Test Plan:
1. Reset with ClocksPerBit=4 → TxSerial=1, Busy=0, Done=0, Address=0, ReadOrWrite=1, CharsSent=0. Holding Start=0 for 50 cycles leaves everything unchanged.
2. RAM loaded with 'E' at address 0 and 7'h00 at address 1, Start pulse at cycle n:
   - TxSerial low over cycles n+3..n+6.
   - Data bits 1,0,1,0,0,0,1,0 (0x45), 4 cycles each.
   - Stop high for 4 cycles.
   - Address=1 in FETCH, NUL detected, Done pulses once, CharsSent=1.
3. Default message (20 non-NUL chars, address 20 = 0x00) → exactly 20 frames decoded by the bench UART monitor: "ECE433 Fall  2020", LF, CR, LF. Then Done, CharsSent=20, Busy low one cycle after Done.
4. All 21 locations non-zero ('A') → 21 frames sent, Address stops at 20 with no wrap, Done pulses, CharsSent=21.
5. Start re-pulsed mid-frame of char 3 → ignored; the frame sequence and timing are identical to scenario 3.
6. Reset asserted in DATA state of char 2 → next edge TxSerial=1, state IDLE, Address=0, Busy=0, no Done pulse. A subsequent Start retransmits from address 0.
